// File: rtl/booth_pkg.sv
// Shared widths and controller state encoding for the Booth multiplier slice.
package booth_pkg;

  localparam int unsigned BOOTH_W      = 16;
  localparam int unsigned BOOTH_PROD_W = 32;
  localparam int unsigned BOOTH_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    HOLD
  } booth_ctrl_state_t;

endpackage

// File: rtl/booth_seq_ctrl.sv
// Sequencer around the radix-2 Booth multiplier: operand handshake, start pulse, result capture.
// Optional BOOTH_ZERO_SKIP_EN: zero operands bypass the multiplier and go straight to HOLD.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH   = BOOTH_W,
  parameter int unsigned TIMEOUT = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_mc,
  output logic [WIDTH-1:0]     mul_mp,
  input  logic                 mul_busy,
  input  logic [2*WIDTH-1:0]   mul_prod,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic                 out_err
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned PROD_W = 2 * WIDTH;

  booth_ctrl_state_t   state, state_nxt;
  logic [CNT_W-1:0]    wait_cnt, wait_cnt_nxt;
  logic                in_ready_nxt, mul_start_nxt, out_valid_nxt, out_err_nxt;
  logic [WIDTH-1:0]    mul_mc_nxt, mul_mp_nxt;
  logic [PROD_W-1:0]   out_prod_nxt;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      in_ready  <= 1'b0;
      mul_start <= 1'b0;
      mul_mc    <= '0;
      mul_mp    <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      in_ready  <= in_ready_nxt;
      mul_start <= mul_start_nxt;
      mul_mc    <= mul_mc_nxt;
      mul_mp    <= mul_mp_nxt;
      out_valid <= out_valid_nxt;
      out_prod  <= out_prod_nxt;
      out_err   <= out_err_nxt;
    end
  end

  // Next-state and next-output logic; flags derive from the state being entered
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mul_mc_nxt   = mul_mc;
    mul_mp_nxt   = mul_mp;
    out_prod_nxt = out_prod;
    out_err_nxt  = out_err;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          mul_mc_nxt = in_a;
          mul_mp_nxt = in_b;
`ifdef BOOTH_ZERO_SKIP_EN
          if ((in_a == '0) || (in_b == '0)) begin
            state_nxt    = HOLD;
            out_prod_nxt = '0;
            out_err_nxt  = 1'b0;
          end else begin
            state_nxt = LAUNCH;
          end
`else
          state_nxt = LAUNCH;
`endif
        end
      end
      // mul_busy still reflects the previous run's counter here
      LAUNCH: begin
        wait_cnt_nxt = '0;
        state_nxt    = WAIT;
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt + CNT_W'(1);
        if (!mul_busy) begin
          out_prod_nxt = mul_prod;
          out_err_nxt  = 1'b0;
          state_nxt    = HOLD;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          out_prod_nxt = '0;
          out_err_nxt  = 1'b1;
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    in_ready_nxt  = (state_nxt == IDLE);
    mul_start_nxt = (state_nxt == LAUNCH);
    out_valid_nxt = (state_nxt == HOLD);
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Randomized self-checking bench for booth_seq_ctrl with a behavioural multiplier stub.
module tb_booth_seq_ctrl;
  import booth_pkg::*;

  localparam int unsigned W  = BOOTH_W;
  localparam int unsigned PW = BOOTH_PROD_W;
  localparam int unsigned TO = 24;
`ifdef BOOTH_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          mul_start, mul_busy;
  logic [W-1:0]  mul_mc, mul_mp;
  logic [PW-1:0] mul_prod;
  logic          out_valid, out_ready = 1'b0, out_err;
  logic [PW-1:0] out_prod;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  booth_seq_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_mc(mul_mc), .mul_mp(mul_mp),
    .mul_busy(mul_busy), .mul_prod(mul_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_err(out_err)
  );

  // Multiplier stand-in: free-running count, product correct only when count==16
  logic [5:0]           m_cnt = 6'd40;
  logic signed [W-1:0]  m_a = '0, m_b = '0;
  logic signed [PW-1:0] m_true;
  logic                 stuck = 1'b0;

  always @(posedge clk) begin
    if (mul_start) begin
      m_cnt <= 6'd0;
      m_a   <= mul_mc;
      m_b   <= mul_mp;
    end else begin
      m_cnt <= m_cnt + 6'd1;
    end
  end
  assign m_true   = m_a * m_b;
  assign mul_prod = (m_cnt == 6'd16) ? m_true : (m_true ^ {16'hA5C3, 10'd0, m_cnt});
  assign mul_busy = stuck | (m_cnt < 6'd16);

  function automatic logic [PW-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return PW'(p);
  endfunction

  // Transaction-level reference: age counts cycles since the accepting edge
  logic          md_active, md_rdy, md_skip, md_err;
  int            md_age, md_lat;
  logic [PW-1:0] md_prod;
  logic [W-1:0]  md_mc, md_mp;
  logic          md_z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_active <= 1'b0; md_rdy <= 1'b0; md_skip <= 1'b0; md_err <= 1'b0;
      md_age <= 0; md_lat <= 0; md_prod <= '0; md_mc <= '0; md_mp <= '0;
    end else begin
      md_rdy <= 1'b1;
      if (!md_active) begin
        if (in_valid && md_rdy) begin
          md_z      = SKIP && ((in_a == '0) || (in_b == '0));
          md_active <= 1'b1;
          md_age    <= 1;
          md_mc     <= in_a;
          md_mp     <= in_b;
          md_skip   <= md_z;
          md_lat    <= md_z ? 1 : (stuck ? 2 + int'(TO) : 2 + int'(BOOTH_CYCLES) + 1);
          md_prod   <= (md_z || stuck) ? '0 : mul_ref(in_a, in_b);
          md_err    <= !md_z && stuck;
        end
      end else if (md_age >= md_lat && out_ready) begin
        md_active <= 1'b0;
      end else begin
        md_age <= md_age + 1;
      end
    end
  end

  logic exp_in_ready, exp_start, exp_valid;
  assign exp_in_ready = md_rdy && !md_active;
  assign exp_start    = md_active && (md_age == 1) && !md_skip;
  assign exp_valid    = md_active && (md_age >= md_lat);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the reference, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_mul_start", 64'(mul_start), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_prod", 64'(out_prod), 64'(0));
      chk("rst_out_err", 64'(out_err), 64'(0));
      chk("rst_mul_mc", 64'(mul_mc), 64'(0));
      chk("rst_mul_mp", 64'(mul_mp), 64'(0));
    end else begin
      chk("in_ready", 64'(in_ready), 64'(exp_in_ready));
      chk("mul_start", 64'(mul_start), 64'(exp_start));
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      chk("mul_mc", 64'(mul_mc), 64'(md_mc));
      chk("mul_mp", 64'(mul_mp), 64'(md_mp));
      if (exp_valid) begin
        chk("out_prod", 64'(out_prod), 64'(md_prod));
        chk("out_err", 64'(out_err), 64'(md_err));
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit done = 1'b0;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (done) begin
      @(posedge clk); #1;
    end else begin
      chk("accept_bound", 64'(0), 64'(1));
    end
    in_valid = 1'b0;
  endtask

  task automatic await_result(input string name, input int lat, input logic [PW-1:0] prod,
                              input logic err, input int hold);
    int  n = 0;
    bit  seen = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin n = i; seen = 1'b1; end
    end
    chk({name, "_latency"}, 64'(n), 64'(lat));
    chk({name, "_model"}, 64'(md_prod), 64'(prod));
    if (seen) begin
      chk({name, "_prod"}, 64'(out_prod), 64'(prod));
      chk({name, "_err"}, 64'(out_err), 64'(err));
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
        @(negedge clk);
        chk({name, "_hold_prod"}, 64'(out_prod), 64'(prod));
        chk({name, "_hold_ready"}, 64'(in_ready), 64'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom % 8)
      0: return '0;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send(16'd3, 16'd5);
    await_result("3x5", 19, 32'h0000_000F, 1'b0, 0);
    send(16'hFFFE, 16'd3);
    await_result("m2x3", 19, 32'hFFFF_FFFA, 1'b0, 0);
    send(16'h8000, 16'h8000);
    await_result("min_sq", 19, 32'h4000_0000, 1'b0, 10);

    stuck = 1'b1;
    send(16'd11, 16'd13);
    await_result("timeout", 26, 32'h0, 1'b1, 2);
    stuck = 1'b0;

    // Reset during the 8th WAIT cycle loses the result
    send(16'd100, 16'hFFFD);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_ready", 64'(in_ready), 64'(0));
    chk("midrst_mc", 64'(mul_mc), 64'(0));
    chk("midrst_start", 64'(mul_start), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(16'd7, 16'd7);
    await_result("7x7", 19, 32'h0000_0031, 1'b0, 0);

    send(16'd0, 16'h1234);
    await_result("zero", SKIP ? 1 : 19, 32'h0, 1'b0, 0);

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 2) == 0;
      in_a      = rnd_op();
      in_b      = rnd_op();
      out_ready = ($urandom % 3) != 0;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
Sequencer that sits directly upstream of the 16-bit radix-2 Booth multiplier and also captures its result.
- Accepts operand pairs over a valid/ready handshake.
- Loads the multiplier with a one-cycle `mul_start` pulse, then watches `mul_busy`.
- Captures `mul_prod` in the single cycle it is valid and presents it downstream over a valid/ready handshake.
- Hides the multiplier's free-running counter, which keeps shifting after completion.

Parameters:
- `WIDTH`, 16: operand width; the product is 2*`WIDTH`.
- `TIMEOUT`, 24: maximum WAIT cycles before the error exit.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: controller can accept a pair.
- `in_a` in `WIDTH`: multiplicand, two's complement.
- `in_b` in `WIDTH`: multiplier, two's complement.
- `mul_start` out 1: load pulse to the multiplier.
- `mul_mc` out `WIDTH`: registered multiplicand to the multiplier.
- `mul_mp` out `WIDTH`: registered multiplier operand to the multiplier.
- `mul_busy` in 1: multiplier busy (count < 16).
- `mul_prod` in 2*`WIDTH`: multiplier result {acc,q}.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_prod` out 2*`WIDTH`: signed product.
- `out_err` out 1: result invalid because of timeout.

Behaviour:
- Clock and reset: one clock, `clk`. `rst_n` is asynchronous and active-low.
- Reset values:
  - state=IDLE
  - `in_ready`=0 while `rst_n` is low, then 1 in IDLE
  - `mul_start`=0, `mul_mc`=0, `mul_mp`=0
  - `out_valid`=0, `out_prod`=0, `out_err`=0
  - wait counter=0
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, register `in_a`→`mul_mc` and `in_b`→`mul_mp`, then go to LAUNCH.
- LAUNCH:
  - `mul_start`=1 for exactly this one cycle.
  - `mul_busy` is ignored here, because it reflects the stale counter.
  - Clear the wait counter and go to WAIT.
- WAIT:
  - The wait counter increments each cycle.
  - If `mul_busy`==0, capture `mul_prod`→`out_prod`, set `out_err`=0 and go to HOLD. This is the first busy-low cycle, the only cycle in which count==16.
  - Else, if the wait counter == `TIMEOUT`-1, set `out_prod`=0, `out_err`=1 and go to HOLD.
- HOLD:
  - `out_valid`=1; `out_prod` and `out_err` stay stable.
  - On `out_ready`, go to IDLE. `out_valid` drops and `in_ready` rises in the next cycle.
- Latency: accept in cycle A → `mul_start` in A+1 → busy low in A+18 → `out_valid` in A+19.
- Throughput: one product per 20 cycles minimum. There is no overlap of accept and HOLD.
- `mul_mc`/`mul_mp` hold their value from accept until the next accept.
- `in_ready`=0 in LAUNCH, WAIT and HOLD. `in_valid` in those states is ignored, not queued.
- Reset asserted mid-WAIT or mid-HOLD: immediate return to the reset values.
  - The result is lost.
  - The multiplier keeps free-running but is ignored until the next LAUNCH.
- Product is two's complement. There is no saturation: (-2^15)*(-2^15) = 0x40000000 is exact.

Optional Feature:
- Macro: `BOOTH_ZERO_SKIP_EN`.
- Defined: at accept, if `in_a`==0 or `in_b`==0, go directly from IDLE to HOLD with `out_prod`=0, `out_err`=0, and no `mul_start` pulse. `out_valid` appears at A+1.
- Undefined: every pair, zero operands included, takes the full LAUNCH/WAIT path.

Decomposition:
- Package `booth_pkg` holds:
  - `BOOTH_W`=16 and `BOOTH_PROD_W`=32
  - `BOOTH_CYCLES`=16
  - typedef enum logic[1:0] `booth_ctrl_state_t` {IDLE, LAUNCH, WAIT, HOLD}
- No sub-module; the wait counter is inline.
- The testbench instantiates `booth_seq_ctrl` together with the existing multiplier.

Test Plan:
- `in_a`=3, `in_b`=5 accepted at cycle A → `mul_start` high only at A+1; `out_valid` at A+19 with `out_prod`=0x0000000F, `out_err`=0.
- `in_a`=0xFFFE (-2), `in_b`=3 → `out_prod`=0xFFFFFFFA; a second pair 0x8000*0x8000 → 0x40000000.
- `out_ready` held low 10 cycles in HOLD → `out_prod` stable, `in_ready`=0, an extra `in_valid` is ignored; `out_ready`=1 → IDLE next cycle.
- Stub holds `mul_busy`=1 forever → HOLD after `TIMEOUT` WAIT cycles with `out_err`=1, `out_prod`=0.
- `rst_n` low at the 8th WAIT cycle → all outputs 0 immediately; the next pair 7*7 yields 0x00000031 with latency 19.
- With `BOOTH_ZERO_SKIP_EN`: `in_a`=0, `in_b`=0x1234 → no `mul_start`, `out_valid` at A+1, `out_prod`=0. Without the macro → latency 19, `out_prod`=0.
